// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Constants shared by the SPI responder and the SPI master:
//               frame field widths, the write-select bit of the command byte
//               and the responder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int CMD_W         = 8;   // command-phase width in bits
  localparam int DATA_W        = 16;  // data-phase width in bits
  localparam int CMD_WRITE_BIT = 7;   // cmd[7] = 1 selects a write frame

  // Responder state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : STAGES-deep flip-flop synchronizer for one asynchronous pin,
//               with single-cycle rise/fall pulses derived from the
//               synchronized level.
// Ports       : clk, rst_n (sync, active low), din (async pin),
//               level (synchronized value), rise / fall (one-clk pulses)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!rst_n) r_sync <= RESET_VAL;
        else        r_sync <= din;
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (!rst_n) r_sync <= {STAGES{RESET_VAL}};
        else        r_sync <= {r_sync[STAGES-2:0], din};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) r_prev <= RESET_VAL;
    else        r_prev <= r_sync[STAGES-1];
  end

  assign level = r_sync[STAGES-1];
  assign rise  = level & ~r_prev;
  assign fall  = ~level & r_prev;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_responder
// Description : Mode-0 SPI slave endpoint. A frame is CMD_W command bits
//               followed by DATA_W data bits. Write frames load reg_out;
//               read frames shift tx_data (captured once per frame) out on
//               miso. All SPI pins are oversampled on clk.
// Ports       : clk, rst_n (sync, active low)
//               sck, cs_n, mosi       - SPI pins from the master
//               miso, miso_oe         - read data and its valid/enable
//               tx_data               - value returned on a read
//               reg_out, wr_strobe    - written register and update pulse
//               rd_strobe             - pulse when tx_data is captured
// Revision    : 1.0 - initial release
// ============================================================================
module spi_responder #(
  parameter int DATA_W      = spi_pkg::DATA_W,
  parameter int CMD_W       = spi_pkg::CMD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] reg_out,
  output logic              wr_strobe,
  output logic              rd_strobe
);

  import spi_pkg::*;

  localparam int CNT_W    = $clog2(DATA_W + 1);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0]    C_CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0]    C_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]    C_DATA_FULL = CNT_W'(DATA_W);
  localparam logic [SETTLE_W-1:0] C_SETTLED   = SETTLE_W'(SYNC_STAGES);

  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_cs_level,  w_cs_rise,  w_cs_fall;
  logic w_mosi,      w_mosi_rise, w_mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .din(sck),
    .level(w_sck_level), .rise(w_sck_rise), .fall(w_sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .level(w_cs_level), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .level(w_mosi), .rise(w_mosi_rise), .fall(w_mosi_fall)
  );

  logic [2:0]          r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [CMD_W-2:0]    r_cmd;
  logic [DATA_W-2:0]   r_data;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_reg;
  logic                r_miso;
  logic                r_miso_oe;
  logic                r_wr_strobe;
  logic                r_rd_strobe;
  logic [SETTLE_W-1:0] r_settle;
  logic                r_armed;

  // Shift register contents including the bit arriving on this rise.
  logic [CMD_W-1:0]  w_cmd_next;
  logic [DATA_W-1:0] w_data_next;
  assign w_cmd_next  = {r_cmd,  w_mosi};
  assign w_data_next = {r_data, w_mosi};

  logic w_unused;
  assign w_unused = ^{w_sck_level, w_mosi_rise, w_mosi_fall, w_cmd_next};

  // The cs_n synchronizer holds its reset value (high) for SYNC_STAGES
  // cycles after reset, so its level is only trusted once r_settle expires.
  // Frames are accepted only after cs_n has genuinely been seen high; this
  // keeps a cs_n that stayed low through reset from starting a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != C_SETTLED) r_settle <= r_settle + 1'b1;
      if (r_settle == C_SETTLED && w_cs_level) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_cmd       <= '0;
      r_data      <= '0;
      r_tx        <= '0;
      r_reg       <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_rd_strobe <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_rd_strobe <= 1'b0;
      // cs_n rising ends the frame from any state and takes priority over
      // an SCK edge detected in the same cycle.
      if (w_cs_rise) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            if (w_cs_fall && r_armed) begin
              r_state   <= ST_CMD;
              r_bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (w_sck_rise) begin
              r_cmd <= w_cmd_next[CMD_W-2:0];
              if (r_bit_cnt == C_CMD_LAST) begin
                r_bit_cnt <= '0;
                if (w_cmd_next[CMD_WRITE_BIT]) begin
                  r_state <= ST_WR;
                end else begin
                  r_tx        <= tx_data;
                  r_rd_strobe <= 1'b1;
                  r_state     <= ST_RD;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          ST_WR: begin
            if (w_sck_rise) begin
              r_data <= w_data_next[DATA_W-2:0];
              if (r_bit_cnt == C_DATA_LAST) begin
                r_reg       <= w_data_next;
                r_wr_strobe <= 1'b1;
                r_state     <= ST_DONE;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          ST_RD: begin
            // Bits go out on falls; the last one stays on miso until the
            // master has sampled it on the following rise.
            if (w_sck_fall && r_bit_cnt != C_DATA_FULL) begin
              r_miso    <= r_tx[DATA_W-1];
              r_tx      <= {r_tx[DATA_W-2:0], 1'b0};
              r_miso_oe <= 1'b1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_sck_rise && r_bit_cnt == C_DATA_FULL) begin
              r_state   <= ST_DONE;
              r_miso    <= 1'b0;
              r_miso_oe <= 1'b0;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign miso      = r_miso;
  assign miso_oe   = r_miso_oe;
  assign reg_out   = r_reg;
  assign wr_strobe = r_wr_strobe;
  assign rd_strobe = r_rd_strobe;

endmodule : spi_responder
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_responder
// Description : Self-checking bench for spi_responder. Acts as a mode-0 SPI
//               master at clk/8, applies a table of frames and a mid-frame
//               reset sequence, and compares strobes, reg_out, read data and
//               strobe latency against expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_responder;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [15:0] tx;
    int          nrise;
    int          exp_wr;
    int          exp_rd;
    logic [15:0] exp_reg;
    bit          chk_rx;
    logic [15:0] exp_rx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, sck, cs_n, mosi;
  logic        miso, miso_oe, wr_strobe, rd_strobe;
  logic [15:0] tx_data, reg_out;

  spi_responder #(.DATA_W(16), .CMD_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .reg_out(reg_out),
    .wr_strobe(wr_strobe), .rd_strobe(rd_strobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling clock edge.
  int wr_cnt = 0, rd_cnt = 0, oe_cnt = 0, wr_cyc = 0, rd_cyc = 0;
  always @(negedge clk) begin
    if (wr_strobe) begin wr_cnt++; wr_cyc = cyc; end
    if (rd_strobe) begin rd_cnt++; rd_cyc = cyc; end
    if (miso_oe) oe_cnt++;
  end

  int          n_cmp = 0, n_bad = 0;
  int          r8_cyc = 0, r24_cyc = 0, oe_miss = 0;
  logic [15:0] rx_shift;
  vec_t        sb[$];
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives SCK rises first..last-1 of a frame; MOSI changes while SCK is low,
  // MISO is sampled just as SCK rises.
  task automatic drive_rises(input logic [7:0] cmd, input logic [15:0] data,
                             input int first, input int last, input bit chg_tx);
    for (int i = first; i < last; i++) begin
      logic b;
      if (i < 8)       b = cmd[7-i];
      else if (i < 24) b = data[23-i];
      else             b = 1'b0;
      mosi = b;
      clk_wait(4);
      if (i >= 8 && i < 24) begin
        rx_shift = {rx_shift[14:0], miso};
        if (!miso_oe) oe_miss++;
      end
      sck = 1'b1;
      if (i == 7)  r8_cyc  = cyc;
      if (i == 23) r24_cyc = cyc;
      if (chg_tx && i == 11) tx_data = ~tx_data;
      clk_wait(4);
      sck = 1'b0;
    end
  endtask

  task automatic run_frame(input vec_t v);
    int   w0, r0, o0;
    vec_t e;
    sb.push_back(v);
    w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cnt;
    oe_miss  = 0;
    rx_shift = '0;
    tx_data  = v.tx;
    cs_n     = 1'b0;
    clk_wait(4);
    drive_rises(v.cmd, v.data, 0, v.nrise, ~v.cmd[7]);
    clk_wait(4);
    cs_n = 1'b1;
    clk_wait(2);
    e = sb.pop_front();
    check("wr_strobe_count", wr_cnt - w0, e.exp_wr);
    check("rd_strobe_count", rd_cnt - r0, e.exp_rd);
    check("reg_out", reg_out, e.exp_reg);
    if (e.exp_wr == 1) check("wr_strobe_latency", wr_cyc - r24_cyc, 3);
    if (e.exp_rd == 1) check("rd_strobe_latency", rd_cyc - r8_cyc, 3);
    if (e.chk_rx) begin
      check("read_data", rx_shift, e.exp_rx);
      check("miso_oe_during_read", oe_miss, 0);
    end
    if (e.exp_rd == 0) check("miso_oe_idle_in_write", oe_cnt - o0, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    vec_t v;
    rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; tx_data = '0;
    clk_wait(4);
    check("reset_reg_out", reg_out, 16'h0000);
    check("reset_miso_oe", miso_oe, 0);
    check("reset_miso", miso, 0);
    check("reset_strobes", {wr_strobe, rd_strobe}, 0);
    rst_n = 1'b1;
    clk_wait(4);

    //             cmd    data      tx       n   wr rd  reg       chk  rx
    vecs[0] = '{8'h80, 16'hBEEF, 16'h0000, 24, 1, 0, 16'hBEEF, 0, 16'h0000};
    vecs[1] = '{8'h00, 16'h0000, 16'h1234, 24, 0, 1, 16'hBEEF, 1, 16'h1234};
    vecs[2] = '{8'h80, 16'hFFFF, 16'h0000, 20, 0, 0, 16'hBEEF, 0, 16'h0000};
    vecs[3] = '{8'h80, 16'h0001, 16'h0000, 24, 1, 0, 16'h0001, 0, 16'h0000};
    vecs[4] = '{8'h80, 16'hA5A5, 16'h0000, 30, 1, 0, 16'hA5A5, 0, 16'h0000};
    vecs[5] = '{8'h7F, 16'h0000, 16'hC3C3, 24, 0, 1, 16'hA5A5, 1, 16'hC3C3};
    vecs[6] = '{8'hFF, 16'h5A5A, 16'h0000, 24, 1, 0, 16'h5A5A, 0, 16'h0000};
    vecs[7] = '{8'h00, 16'h0000, 16'h8001, 12, 0, 1, 16'h5A5A, 0, 16'h0000};

    for (int k = 0; k < 8; k++) run_frame(vecs[k]);

    // Reset pulse in the data phase of a write, cs_n held low throughout.
    w0 = wr_cnt;
    cs_n = 1'b0;
    clk_wait(4);
    drive_rises(8'h80, 16'h1111, 0, 14, 1'b0);
    rst_n = 1'b0;
    clk_wait(1);
    rst_n = 1'b1;
    check("midreset_reg_out", reg_out, 16'h0000);
    check("midreset_miso_oe", miso_oe, 0);
    check("midreset_miso", miso, 0);
    check("midreset_strobes", {wr_strobe, rd_strobe}, 0);
    drive_rises(8'h80, 16'h1111, 14, 24, 1'b0);
    clk_wait(6);
    check("post_reset_no_commit", wr_cnt - w0, 0);
    check("post_reset_reg_out", reg_out, 16'h0000);
    cs_n = 1'b1;
    clk_wait(2);

    v = '{8'h80, 16'h2222, 16'h0000, 24, 1, 0, 16'h2222, 0, 16'h0000};
    run_frame(v);
    clk_wait(6);
    check("final_miso_oe", miso_oe, 0);
    check("final_miso", miso, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_spi_responder
`default_nettype wire
